// File: rtl/writeback_unit.sv
// Writeback stage: merges buffered ALU results and formatted load data
// onto the single register file write port.
module writeback_unit #(
    parameter int RISC_V_DATA_WIDTH           = 32,
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int ALU_FIFO_DEPTH              = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alu_valid,
    output logic                                   alu_ready,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [RISC_V_DATA_WIDTH-1:0]           alu_data,
    input  logic                                   ld_req_valid,
    output logic                                   ld_req_ready,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ld_rd,
    input  logic [2:0]                             ld_funct3,
    input  logic [1:0]                             ld_offset,
    input  logic                                   mem_rvalid,
    input  logic [RISC_V_DATA_WIDTH-1:0]           mem_rdata,
    output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] reg_num_w,
    output logic [RISC_V_DATA_WIDTH-1:0]           w_data,
    output logic                                   ctrl_reg_w,
    output logic                                   ld_busy,
    output logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ld_pend_rd
);
    localparam int AW = REGISTER_FILE_ADDRESS_WIDTH;
    localparam int DW = RISC_V_DATA_WIDTH;
    localparam int PW = $clog2(ALU_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic [AW+DW-1:0] fifo_q [ALU_FIFO_DEPTH];
    logic [AW+DW-1:0] fifo_d [ALU_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   reg_num_w_q, reg_num_w_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic            ctrl_reg_w_q, ctrl_reg_w_d;

    logic            fifo_empty, alu_acc, ld_acc, ld_ret;
    logic            sel_fifo, sel_byp, push, pop;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [DW-1:0]   ld_fmt;
    logic [AW-1:0]   head_rd;
    logic [DW-1:0]   head_data;

    assign fifo_empty   = (cnt_q == '0);
    assign alu_ready    = (cnt_q != CW'(ALU_FIFO_DEPTH));
    assign ld_req_ready = (state_q == IDLE);
    assign ld_busy      = (state_q == WAIT);
    assign ld_pend_rd   = (state_q == WAIT) ? ld_rd_q : '0;
    assign reg_num_w    = reg_num_w_q;
    assign w_data       = w_data_q;
    assign ctrl_reg_w   = ctrl_reg_w_q;

    assign alu_acc  = alu_valid && alu_ready;
    assign ld_acc   = ld_req_valid && ld_req_ready;
    assign ld_ret   = mem_rvalid && (state_q == WAIT);
    assign sel_fifo = !ld_ret && !fifo_empty;
    assign sel_byp  = !ld_ret && fifo_empty && alu_acc;
    assign push     = alu_acc && !sel_byp;
    assign pop      = sel_fifo;

    assign {head_rd, head_data} = fifo_q[rd_ptr_q];

    // Little-endian lane extraction ahead of sign/zero extension
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (ld_off_q)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_fmt = {{(DW-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{(DW-16){ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {{(DW-8){1'b0}}, ld_byte};
            3'b101:  ld_fmt = {{(DW-16){1'b0}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        case (state_q)
            IDLE: if (ld_acc) begin
                state_d  = WAIT;
                ld_rd_d  = ld_rd;
                ld_f3_d  = ld_funct3;
                ld_off_d = ld_offset;
            end
            WAIT: if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {alu_rd, alu_data};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // x0 targets are consumed but never raise the write enable
    always_comb begin
        reg_num_w_d  = reg_num_w_q;
        w_data_d     = w_data_q;
        ctrl_reg_w_d = 1'b0;
        unique case (1'b1)
            ld_ret: begin
                reg_num_w_d  = ld_rd_q;
                w_data_d     = ld_fmt;
                ctrl_reg_w_d = (ld_rd_q != '0);
            end
            sel_fifo: begin
                reg_num_w_d  = head_rd;
                w_data_d     = head_data;
                ctrl_reg_w_d = (head_rd != '0);
            end
            sel_byp: begin
                reg_num_w_d  = alu_rd;
                w_data_d     = alu_data;
                ctrl_reg_w_d = (alu_rd != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ld_rd_q      <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            reg_num_w_q  <= '0;
            w_data_q     <= '0;
            ctrl_reg_w_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            reg_num_w_q  <= reg_num_w_d;
            w_data_q     <= w_data_d;
            ctrl_reg_w_q <= ctrl_reg_w_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load formatting,
// collisions, FIFO backpressure, x0 suppression and reset mid-load.
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_num_w;
    logic [31:0] w_data;
    logic        ctrl_reg_w;
    logic        ld_busy;
    logic [4:0]  ld_pend_rd;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_offset(ld_offset),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .reg_num_w(reg_num_w), .w_data(w_data), .ctrl_reg_w(ctrl_reg_w),
        .ld_busy(ld_busy), .ld_pend_rd(ld_pend_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [4:0] rd,
                      input logic [31:0] d);
        chk({tag, ".we"}, 32'(ctrl_reg_w), 32'd1);
        chk({tag, ".rd"}, 32'(reg_num_w), 32'(rd));
        chk({tag, ".data"}, w_data, d);
    endtask

    task automatic load(input string tag, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] rdata, input logic [31:0] exp);
        ld_req_valid = 1'b1;
        ld_rd = rd;
        ld_funct3 = f3;
        ld_offset = off;
        tick();
        ld_req_valid = 1'b0;
        ld_rd = 5'd31;
        ld_funct3 = 3'b111;
        ld_offset = 2'd3;
        chk({tag, ".busy"}, 32'(ld_busy), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        wr(tag, rd, exp);
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0;
        alu_rd = '0;
        alu_data = '0;
        ld_req_valid = 1'b0;
        ld_rd = '0;
        ld_funct3 = '0;
        ld_offset = '0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst.we", 32'(ctrl_reg_w), 32'd0);
        chk("rst.rd", 32'(reg_num_w), 32'd0);
        chk("rst.data", w_data, 32'd0);
        chk("rst.alu_ready", 32'(alu_ready), 32'd1);
        chk("rst.ld_req_ready", 32'(ld_req_ready), 32'd1);
        chk("rst.ld_busy", 32'(ld_busy), 32'd0);
        chk("rst.ld_pend_rd", 32'(ld_pend_rd), 32'd0);
        rst = 1'b1;
        tick();

        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        wr("alu1", 5'd5, 32'h1234_5678);
        tick();
        chk("alu1.idle_we", 32'(ctrl_reg_w), 32'd0);
        chk("alu1.hold_rd", 32'(reg_num_w), 32'd5);

        ld_req_valid = 1'b1;
        ld_rd = 5'd3;
        ld_funct3 = 3'b000;
        ld_offset = 2'd1;
        tick();
        ld_req_valid = 1'b0;
        chk("bp.busy", 32'(ld_busy), 32'd1);
        chk("bp.pend_rd", 32'(ld_pend_rd), 32'd3);
        chk("bp.req_ready", 32'(ld_req_ready), 32'd0);
        tick();
        tick();
        chk("bp.busy2", 32'(ld_busy), 32'd1);
        chk("bp.req_ready2", 32'(ld_req_ready), 32'd0);
        chk("bp.we", 32'(ctrl_reg_w), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0000_80FF;
        tick();
        mem_rvalid = 1'b0;
        wr("lb", 5'd3, 32'hFFFF_FF80);
        chk("lb.busy_clr", 32'(ld_busy), 32'd0);
        chk("lb.req_ready", 32'(ld_req_ready), 32'd1);

        load("lbu", 5'd4, 3'b100, 2'd1, 32'h0000_80FF, 32'h0000_0080);
        load("lh", 5'd6, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
        load("lw", 5'd9, 3'b010, 2'd0, 32'h8001_0000, 32'h8001_0000);
        load("lhu", 5'd2, 3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D);
        load("lb3", 5'd1, 3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);

        ld_req_valid = 1'b1;
        ld_rd = 5'd7;
        ld_funct3 = 3'b010;
        ld_offset = 2'd0;
        tick();
        ld_req_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        alu_valid = 1'b1;
        alu_rd = 5'd8;
        alu_data = 32'h1;
        tick();
        mem_rvalid = 1'b0;
        alu_valid = 1'b0;
        wr("col.ld", 5'd7, 32'hAAAA_5555);
        chk("col.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        wr("col.alu", 5'd8, 32'h1);
        tick();
        chk("col.idle_we", 32'(ctrl_reg_w), 32'd0);

        alu_valid = 1'b1;
        alu_rd = 5'd0;
        alu_data = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        chk("x0alu.we", 32'(ctrl_reg_w), 32'd0);
        tick();
        chk("x0alu.we2", 32'(ctrl_reg_w), 32'd0);
        ld_req_valid = 1'b1;
        ld_rd = 5'd0;
        ld_funct3 = 3'b010;
        tick();
        ld_req_valid = 1'b0;
        chk("x0ld.busy", 32'(ld_busy), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("x0ld.we", 32'(ctrl_reg_w), 32'd0);
        chk("x0ld.busy_clr", 32'(ld_busy), 32'd0);

        ld_req_valid = 1'b1;
        ld_rd = 5'd10;
        ld_funct3 = 3'b010;
        tick();
        ld_req_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h100;
        alu_valid = 1'b1;
        alu_rd = 5'd11;
        alu_data = 32'hB;
        tick();
        wr("fill.x10", 5'd10, 32'h100);
        mem_rvalid = 1'b0;
        ld_req_valid = 1'b1;
        ld_rd = 5'd12;
        alu_rd = 5'd13;
        alu_data = 32'hD;
        tick();
        wr("fill.x11", 5'd11, 32'hB);
        chk("fill.busy", 32'(ld_busy), 32'd1);
        ld_req_valid = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h200;
        alu_rd = 5'd14;
        alu_data = 32'hE;
        tick();
        wr("fill.x12", 5'd12, 32'h200);
        chk("fill.full", 32'(alu_ready), 32'd0);
        mem_rvalid = 1'b0;
        alu_rd = 5'd15;
        alu_data = 32'hF;
        tick();
        wr("drain.x13", 5'd13, 32'hD);
        chk("drain.ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        wr("drain.x14", 5'd14, 32'hE);
        tick();
        wr("drain.x15", 5'd15, 32'hF);
        tick();
        chk("drain.idle_we", 32'(ctrl_reg_w), 32'd0);
        chk("drain.ready2", 32'(alu_ready), 32'd1);

        ld_req_valid = 1'b1;
        ld_rd = 5'd9;
        ld_funct3 = 3'b010;
        tick();
        ld_req_valid = 1'b0;
        chk("rml.busy", 32'(ld_busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_rvalid = 1'b0;
        chk("rml.we", 32'(ctrl_reg_w), 32'd0);
        chk("rml.rd", 32'(reg_num_w), 32'd0);
        chk("rml.busy_clr", 32'(ld_busy), 32'd0);
        chk("rml.req_ready", 32'(ld_req_ready), 32'd1);
        tick();
        chk("rml.we2", 32'(ctrl_reg_w), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
